// File: rtl/leaf_fifo_stage.sv
// leaf_fifo_stage: DEPTH-entry valid/ready FIFO that decouples producer and
// consumer stalls. It reports its occupancy and a wrapping count of completed
// output transfers. Full and empty are taken from the occupancy counter, so
// the pointers can wrap freely. Storage is not reset; only the control state is.
module leaf_fifo_stage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                xfer_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Handshake qualifiers. Ready and valid come only from the registered count,
  // so the in_* ports have no combinational path to the out_* ports.
  always_comb begin
    in_ready  = (count != CW'(DEPTH));
    out_valid = (count != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    out_data  = storage[rd_ptr];
  end

  // Payload storage: written on push only, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      storage[wr_ptr] <= in_data;
    end
  end

  // Pointers, occupancy and transfer counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      xfer_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        xfer_cnt <= xfer_cnt + 16'd1;
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_leaf_fifo_stage.sv
// Testbench for leaf_fifo_stage: directed stimulus pushes the expected output
// word into a queue whenever it offers a word that must be accepted. A separate
// monitor pops the queue on every output handshake and compares out_data.
module tb_leaf_fifo_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [2:0]  count;
  logic [15:0] xfer_cnt;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  leaf_fifo_stage #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(d);
  endtask

  // Monitor: a handshake visible at the falling edge retires at the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0h required=none", out_data);
      end else begin
        check("out_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic [7:0] fill_vals [4];
    int n;
    fill_vals[0] = 8'h11; fill_vals[1] = 8'h22; fill_vals[2] = 8'h33; fill_vals[3] = 8'h44;

    // reset state
    #1 rst = 1'b1;
    #11;
    check("reset_count", {29'h0, count}, 32'd0);
    check("reset_out_valid", {31'h0, out_valid}, 32'd0);
    check("reset_in_ready", {31'h0, in_ready}, 32'd1);
    check("reset_xfer", {16'h0, xfer_cnt}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // fill with consumer stalled
    for (int i = 0; i < 4; i++) begin
      offer(fill_vals[i]);
      step();
      check("fill_count", {29'h0, count}, i + 1);
    end
    check("full_in_ready", {31'h0, in_ready}, 32'd0);

    // full with a push offered while consumer pops: push must be refused
    in_valid  = 1'b1;
    in_data   = 8'h55;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("full_pop_count", {29'h0, count}, 32'd3);
    check("full_pop_xfer", {16'h0, xfer_cnt}, 32'd1);

    // drain
    n = 0;
    while (out_valid === 1'b1 && n < 10) begin
      step();
      n++;
    end
    check("drain_out_valid", {31'h0, out_valid}, 32'd0);
    check("drain_count", {29'h0, count}, 32'd0);
    check("drain_xfer", {16'h0, xfer_cnt}, 32'd4);
    check("drain_queue_left", exp_q.size(), 32'd0);

    // streaming at count=1 across pointer wrap
    out_ready = 1'b0;
    offer(8'hF0);
    step();
    check("stream_pre_count", {29'h0, count}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(8'(i));
      step();
      check("stream_count", {29'h0, count}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_end_count", {29'h0, count}, 32'd0);
    check("stream_xfer", {16'h0, xfer_cnt}, 32'd15);
    check("stream_queue_left", exp_q.size(), 32'd0);

    // transfer counter wrap: reset, then 65537 pops
    out_ready = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    #2 rst = 1'b0;
    offer(8'h00);
    step();
    out_ready = 1'b1;
    for (int i = 1; i <= 65536; i++) begin
      offer(8'(i));
      step();
    end
    in_valid = 1'b0;
    step();
    check("wrap_xfer", {16'h0, xfer_cnt}, 32'h0001);
    check("wrap_count", {29'h0, count}, 32'd0);

    // async reset mid-operation
    out_ready = 1'b0;
    offer(8'h61); step();
    offer(8'h62); step();
    offer(8'h63); step();
    in_valid = 1'b0;
    check("pre_reset_count", {29'h0, count}, 32'd3);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_count", {29'h0, count}, 32'd0);
    check("async_out_valid", {31'h0, out_valid}, 32'd0);
    check("async_in_ready", {31'h0, in_ready}, 32'd1);
    check("async_xfer", {16'h0, xfer_cnt}, 32'd0);
    @(negedge clk) rst = 1'b0;
    offer(8'hAA);
    step();
    in_valid = 1'b0;
    check("post_reset_count", {29'h0, count}, 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_reset_xfer", {16'h0, xfer_cnt}, 32'd1);
    check("post_reset_queue_left", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
